// File: rtl/em_ttl_pkg.sv
// Shared definitions for the TTL-family counter emulations.
package em_ttl_pkg;

    // Counting direction as seen on the 'down' pin
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest counter any TTL emulation in this family is expected to use
    localparam int EM_WIDTH_MAX = 16;

endpackage

// File: rtl/em_74191_if.sv
// Pin bundle of the 74191 up/down counter; clk and clr stay outside.
interface em_74191_if #(
    parameter int WIDTH = 4
);
    logic             nload;
    logic             nenable;
    logic             down;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] count;
    logic             max_min;
    logic             nrco;

    // Driver side (board / testbench / lower cascade logic)
    modport master (
        output nload, nenable, down, parallel_in,
        input  count, max_min, nrco
    );

    // Counter side
    modport slave (
        input  nload, nenable, down, parallel_in,
        output count, max_min, nrco
    );
endinterface

// File: rtl/em_74191_tc.sv
// Terminal-count decode: purely combinational so a cascaded upper stage
// sees nrco in the same cycle the lower stage reaches its limit.
module em_74191_tc
    import em_ttl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             down_i,
    input  logic             nenable_i,
    output logic             max_min_o,
    output logic             nrco_o
);

    // Terminal value depends on direction: all-ones going up, zero going down
    always_comb begin
        max_min_o = 1'b0;
        if (down_i == DIR_DOWN) begin
            max_min_o = (count_i == '0);
        end else begin
            max_min_o = (count_i == '1);
        end
        nrco_o = ~(max_min_o & ~nenable_i);
    end

endmodule

// File: rtl/em_74191.sv
// 74191-style synchronous up/down counter with parallel load and
// ripple carry/borrow output for cascading.
module em_74191
    import em_ttl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    em_74191_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             max_min;
    logic             nrco;

    // Next count: load beats count beats hold; wrap is natural modulo 2^WIDTH
    always_comb begin
        count_d = count_q;
        if (!bus.nload) begin
            count_d = bus.parallel_in;
        end else if (!bus.nenable) begin
            if (bus.down == DIR_DOWN) begin
                count_d = count_q - ONE;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Only state in the block; clr overrides everything on the edge
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    em_74191_tc #(
        .WIDTH (WIDTH)
    ) u_tc (
        .count_i   (count_q),
        .down_i    (bus.down),
        .nenable_i (bus.nenable),
        .max_min_o (max_min),
        .nrco_o    (nrco)
    );

    assign bus.count   = count_q;
    assign bus.max_min = max_min;
    assign bus.nrco    = nrco;

endmodule

// File: doc/em_74191.md
EM_74191 -- requirements
Module: em_74191

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, counter width in bits; legal range 1..16.
REQ-002 SHALL provide port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: clr  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port: nload  input  1  active-low synchronous parallel load.
REQ-005 SHALL provide port: nenable  input  1  active-low count enable (CTEN).
REQ-006 SHALL provide port: down  input  1  direction; 0 = up, 1 = down.
REQ-007 SHALL provide port: parallel_in  input  WIDTH  load data.
REQ-008 SHALL provide port: count  output  WIDTH  registered counter value.
REQ-009 SHALL provide port: max_min  output  1  combinational terminal-count flag.
REQ-010 SHALL provide port: nrco  output  1  combinational active-low ripple carry/borrow for cascading.

Function
REQ-011 SHALL apply per-edge priority: clr > load (nload=0) > count (nenable=0) > hold.
REQ-012 SHALL load count <= parallel_in on an edge with clr=0, nload=0, regardless of nenable and down.
REQ-013 SHALL increment count modulo 2^WIDTH on an edge with clr=0, nload=1, nenable=0, down=0.
REQ-014 SHALL decrement count modulo 2^WIDTH on an edge with clr=0, nload=1, nenable=0, down=1.
REQ-015 SHALL hold count on an edge with clr=0, nload=1, nenable=1.
REQ-016 SHALL wrap: up from all-ones gives 0; down from 0 gives all-ones; no sticky overflow state.
REQ-017 SHALL drive max_min=1 iff (down=0 and count=all-ones) or (down=1 and count=0), independent of nenable.
REQ-018 SHALL drive nrco=0 iff max_min=1 and nenable=0; otherwise nrco=1.
REQ-019 SHALL give max_min and nrco zero-cycle latency from down, nenable and count; no register on either.
REQ-020 SHALL apply a change of down at the next counting edge for count; max_min follows immediately.
REQ-021 SHALL have a one-edge load latency: count equals parallel_in after the loading edge.
REQ-022 SHALL support synchronous cascading: upper stage nenable driven by lower stage nrco, with all stages on the same clk, down and nload.

Reset
REQ-023 SHALL set count=0 on any rising edge with clr=1, overriding nload and nenable.
REQ-024 SHALL produce post-reset outputs derived from REQ-017/018: down=1 gives max_min=1, down=0 gives max_min=0.
REQ-025 SHALL abandon any load or count in progress when clr asserts mid-operation; no state other than count exists.
REQ-026 SHALL resume counting from 0 on the first edge with clr=0.

Structure
REQ-027 SHALL place direction constants DIR_UP=0 and DIR_DOWN=1 in shared package em_ttl_pkg for reuse by later TTL emulations.
REQ-028 SHALL implement terminal-count detection (max_min, nrco) in one sub-module em_74191_tc, parameterised by WIDTH.
REQ-029 SHALL keep all sequential logic in a single clocked process in em_74191.

Verification
REQ-030 SHALL test clr priority: count=7, clr=1, nload=0, parallel_in=9, nenable=0 -> count=0 after the edge.
REQ-031 SHALL test load with counting disabled: nload=0, parallel_in=13, nenable=1 -> count=13; then nload=1 for 3 edges -> count stays 13.
REQ-032 SHALL test up wrap: load 14, down=0, nenable=0 -> count 15 (max_min=1, nrco=0), then 0 (max_min=0, nrco=1).
REQ-033 SHALL test down wrap: load 1, down=1, nenable=0 -> count 0 (max_min=1, nrco=0), then 15 (max_min=0).
REQ-034 SHALL test combinational response: count=15, no clock, toggle down 0->1 -> max_min 1->0; set nenable=1 -> nrco=1.
REQ-035 SHALL test an 8-bit cascade of two instances: load 8'h0F, count up -> 8'h10 after one edge; then down -> 8'h0F after one edge.
